// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the synchronous FIFO slice.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    function automatic int countWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer: counts 0..DEPTH-1 and wraps, with a synchronous clear.
module fifo_wrap_ptr #(
    parameter int DEPTH = 8,
    parameter int PW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    // Wrap explicitly so non-power-of-two depths never index past the array.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with optional first-word-fall-through read, threshold flags
// and sticky overflow/underflow indicators.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 17,
    parameter int DEPTH     = 8,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = countWidth(DEPTH);
    localparam int PW = ptrWidth(DEPTH);

    if (WIDTH < 1) begin : gBadWidth
        $error("param_sync_fifo: WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : gBadDepth
        $error("param_sync_fifo: DEPTH must be >= 2");
    end
    if (FWFT != 0 && FWFT != 1) begin : gBadFwft
        $error("param_sync_fifo: FWFT must be 0 or 1");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : gBadAf
        $error("param_sync_fifo: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : gBadAe
        $error("param_sync_fifo: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             rdAccept;
    logic             wrAccept;
    logic             overflowReg;
    logic             underflowReg;
    fifo_status_t     status;

    // A read frees a slot in the same cycle, so a full FIFO can still take a write.
    assign rdAccept = rd_en && !status.empty && !flush;
    assign wrAccept = wr_en && !flush && (!status.full || rdAccept);

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) uWrPtr (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (wrAccept),
        .ptr   (wrPtr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) uRdPtr (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (rdAccept),
        .ptr   (rdPtr)
    );

    always_ff @(posedge clk) begin
        if (wrAccept) begin
            mem[wrPtr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else if (wrAccept && !rdAccept) begin
            count <= count + CW'(1);
        end else if (rdAccept && !wrAccept) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            overflowReg  <= 1'b0;
            underflowReg <= 1'b0;
        end else begin
            if (wr_en && status.full && !rdAccept) begin
                overflowReg <= 1'b1;
            end
            if (rd_en && status.empty) begin
                underflowReg <= 1'b1;
            end
        end
    end

    always_comb begin
        status              = '0;
        status.full         = (count == CW'(DEPTH));
        status.empty        = (count == '0);
        status.almost_full  = (count >= CW'(AF_THRESH));
        status.almost_empty = (count <= CW'(AE_THRESH));
        status.overflow     = overflowReg;
        status.underflow    = underflowReg;
    end

    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;

    // An empty FWFT FIFO presents zero rather than stale, unreset storage.
    if (FWFT != 0) begin : gFwft
        assign rd_data  = status.empty ? '0 : mem[rdPtr];
        assign rd_valid = !status.empty;
    end else begin : gRegRead
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= rdAccept;
                if (rdAccept) begin
                    rd_data <= mem[rdPtr];
                end
            end
        end
    end

endmodule
